// File: rtl/bram_shr_driver_pkg.sv
//------------------------------------------------------------------------------
// bram_shr_pkg : shared FSM state type and default widths for bram_shr_driver
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bram_shr_pkg;

  localparam int DIN_N_DEF  = 8;
  localparam int DOUT_N_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    STROBE  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } state_e;

  // Counter must index the longer of the two words; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_shr_driver_if.sv
//------------------------------------------------------------------------------
// bram_shr_driver_if : tx/rx valid-ready bus between a host and bram_shr_driver
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bram_shr_driver_if
  import bram_shr_pkg::*;
#(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF
);

  logic [DIN_N-1:0]  tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DOUT_N-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

endinterface

`default_nettype wire

// File: rtl/bram_shr_driver_sync2.sv
//------------------------------------------------------------------------------
// bram_shr_sync2 : two-flop synchroniser, async active-low reset to 0
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bram_shr_sync2
  import bram_shr_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/bram_shr_driver.sv
//------------------------------------------------------------------------------
// bram_shr_driver : serialises a word to the harness, strobes it, deserialises
// the reply. Option BRAM_SHR_DRV_SYNC_EN adds a do_i synchroniser + 2-cycle WAIT.
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bram_shr_driver
  import bram_shr_pkg::*;
#(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF
)(
  input  wire logic           clk,
  input  wire logic           rst_n,
  bram_shr_driver_if.slave    bus,
  output logic                di_o,
  output logic                stb_o,
  input  wire logic           do_i,
  output logic                busy
);

  localparam int CNT_W = cnt_width(DIN_N, DOUT_N);

  localparam logic [2:0] c_st_idle    = IDLE;
  localparam logic [2:0] c_st_shift   = SHIFT;
  localparam logic [2:0] c_st_strobe  = STROBE;
  localparam logic [2:0] c_st_wait    = WAIT;
  localparam logic [2:0] c_st_capture = CAPTURE;
  localparam logic [2:0] c_st_hold    = HOLD;

  localparam logic [CNT_W-1:0] c_din_last  = CNT_W'(DIN_N - 1);
  localparam logic [CNT_W-1:0] c_dout_last = CNT_W'(DOUT_N - 1);
  localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DIN_N-1:0]  r_tx_shr;
  logic [DOUT_N-1:0] r_rx_shr;
  logic [DOUT_N-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_tx_ready;
  logic              r_di;
  logic              r_stb;
  logic              r_busy;

  logic              w_do;
  logic [DOUT_N-1:0] w_rx_next;

`ifdef BRAM_SHR_DRV_SYNC_EN
  bram_shr_sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (do_i),
    .o_q   (w_do)
  );
`else
  assign w_do = do_i;
`endif

  generate
    if (DOUT_N == 1) begin : g_rx_one
      assign w_rx_next = w_do;
    end else begin : g_rx_wide
      assign w_rx_next = {r_rx_shr[DOUT_N-2:0], w_do};
    end
  endgenerate

  // di_o is registered, so the MSB is launched on the accept edge and the
  // shift register holds only the bits still to be sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_cnt      <= '0;
      r_tx_shr   <= '0;
      r_rx_shr   <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_di       <= 1'b0;
      r_stb      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (r_tx_ready && bus.tx_valid) begin
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_shr   <= bus.tx_data << 1;
            r_di       <= bus.tx_data[DIN_N-1];
            r_cnt      <= c_din_last;
            r_state    <= c_st_shift;
          end else begin
            r_tx_ready <= 1'b1;
          end
        end

        c_st_shift: begin
          if (r_cnt == '0) begin
            r_di    <= 1'b0;
            r_stb   <= 1'b1;
            r_state <= c_st_strobe;
          end else begin
            r_di     <= r_tx_shr[DIN_N-1];
            r_tx_shr <= r_tx_shr << 1;
            r_cnt    <= r_cnt - 1'b1;
          end
        end

        c_st_strobe: begin
          r_stb <= 1'b0;
`ifdef BRAM_SHR_DRV_SYNC_EN
          r_cnt   <= c_wait_last;
          r_state <= c_st_wait;
`else
          r_cnt   <= c_dout_last;
          r_state <= c_st_capture;
`endif
        end

        // Covers the two-flop latency so the first capture sees the harness MSB.
        c_st_wait: begin
          if (r_cnt == '0) begin
            r_cnt   <= c_dout_last;
            r_state <= c_st_capture;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        c_st_capture: begin
          r_rx_shr <= w_rx_next;
          if (r_cnt == '0) begin
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
            r_state    <= c_st_hold;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        c_st_hold: begin
          if (r_rx_valid && bus.rx_ready) begin
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_state    <= c_st_idle;
          end
        end

        default: begin
          r_state    <= c_st_idle;
          r_rx_valid <= 1'b0;
          r_tx_ready <= 1'b0;
          r_di       <= 1'b0;
          r_stb      <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign di_o         = r_di;
  assign stb_o        = r_stb;
  assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bram_shr_driver.sv
//------------------------------------------------------------------------------
// tb_bram_shr_driver : drives bram_shr_driver against a behavioural harness
// that returns the complement of the word it latched on stb.
//------------------------------------------------------------------------------
`default_nettype none

module tb_bram_shr_driver;

  localparam int DIN_N  = 8;
  localparam int DOUT_N = 8;
`ifdef BRAM_SHR_DRV_SYNC_EN
  localparam int LAT = DIN_N + DOUT_N + 4;
`else
  localparam int LAT = DIN_N + DOUT_N + 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic di_o, stb_o, do_i, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bram_shr_driver_if #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) bus ();

  bram_shr_driver #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .di_o  (di_o),
    .stb_o (stb_o),
    .do_i  (do_i),
    .busy  (busy)
  );

  // Harness: shifts di in, swaps in ~din on stb, shifts dout out MSB-first.
  logic [DIN_N-1:0]  h_din;
  logic [DOUT_N-1:0] h_dout;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_din  <= '0;
      h_dout <= '0;
    end else if (stb_o) begin
      h_dout <= ~h_din;
    end else begin
      h_din  <= {h_din[DIN_N-2:0], di_o};
      h_dout <= h_dout << 1;
    end
  end
  assign do_i = h_dout[DOUT_N-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
    chk("tx_ready_wait", bus.tx_ready, 1);
  endtask

  // One transaction; rx_ready held low for 'hold' cycles of rx_valid.
  task automatic run_txn(input logic [DIN_N-1:0] d, input int hold);
    logic [DOUT_N-1:0] exp_rx;
    logic exp_di;
    exp_rx = ~d;
    wait_ready();
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    bus.rx_ready = (hold == 0);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = DIN_N'($urandom);
    for (int c = 1; c <= LAT + hold + 1; c++) begin
      exp_di = 1'b0;
      if (c <= DIN_N) exp_di = d[DIN_N-c];
      chk("di_o", di_o, exp_di);
      chk("stb_o", stb_o, c == DIN_N + 1);
      chk("rx_valid", bus.rx_valid, (c >= LAT) && (c <= LAT + hold));
      if (c >= LAT) chk("rx_data", bus.rx_data, exp_rx);
      chk("tx_ready", bus.tx_ready, c == LAT + hold + 1);
      chk("busy", busy, c <= LAT + hold);
      if (c == LAT + hold) bus.rx_ready = 1'b1;
      if (c <= LAT + hold) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc[2];
    logic [DOUT_N-1:0] rxd[2];
    int nacc, nrx;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", bus.tx_ready, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_di", di_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tx_ready_after_rst", bus.tx_ready, 1);

    // Directed A5 -> 5A
    run_txn(8'hA5, 0);

    // Back-to-back 00 then FF with tx_valid held
    bus.rx_ready = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    nacc = 0;
    nrx  = 0;
    for (int t = 0; t < 120 && nrx < 2; t++) begin
      if (bus.tx_ready && bus.tx_valid && nacc < 2) begin acc[nacc] = t; nacc++; end
      if (bus.rx_valid) begin rxd[nrx] = bus.rx_data; nrx++; end
      @(negedge clk);
      if (nacc == 1) bus.tx_data = 8'hFF;
      if (nacc == 2) bus.tx_valid = 1'b0;
    end
    chk("b2b_accepts", nacc, 2);
    chk("b2b_results", nrx, 2);
    if (nacc == 2) chk("b2b_spacing", acc[1] - acc[0], LAT + 1);
    if (nrx == 2) begin
      chk("b2b_rx0", rxd[0], 8'hFF);
      chk("b2b_rx1", rxd[1], 8'h00);
    end

    // Backpressure: rx_ready low for 10 cycles
    run_txn(8'h3C, 10);

    // Reset during cycle 5 of SHIFT
    wait_ready();
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_ready", bus.tx_ready, 0);
    chk("mid_rst_rx_valid", bus.rx_valid, 0);
    chk("mid_rst_rx_data", bus.rx_data, 0);
    chk("mid_rst_di", di_o, 0);
    chk("mid_rst_stb", stb_o, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    chk("in_rst_stb", stb_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tx_ready_after_rst2", bus.tx_ready, 1);
    run_txn(8'h81, 0);

    // Randomized words and consumer stalls
    for (int k = 0; k < 8; k++) begin
      run_txn(DIN_N'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
